// File: rtl/sram_pwr_macro_model_if.sv
// Bus bundle between an IM/DM wrapper (master) and the SRAM power macro model (slave).
// Carries the access port, the three sleep request levels and the status outputs.
interface sram_pwr_macro_model_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
);
   logic              CEB;
   logic              WEB;
   logic [ADDR_W-1:0] A;
   logic [DATA_W-1:0] D;
   logic [DATA_W-1:0] BWEB;
   logic              SLP;
   logic              DSLP;
   logic              SD;
   logic [DATA_W-1:0] Q;
   logic              PUDELAY;
   logic              READY;
   logic              ACC_ERR;

   modport master (
      output CEB, WEB, A, D, BWEB, SLP, DSLP, SD,
      input  Q, PUDELAY, READY, ACC_ERR
   );

   modport slave (
      input  CEB, WEB, A, D, BWEB, SLP, DSLP, SD,
      output Q, PUDELAY, READY, ACC_ERR
   );
endinterface

// File: rtl/sram_pwr_macro_model.sv
// Behavioural single-port SRAM macro with per-bit write enable and a low-power
// controller (light sleep, deep sleep, shutdown, timed wake-up).
// Optional feature macro: SRAM_OUT_REG_EN adds a second output register (read latency 2).
module sram_pwr_macro_model #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16384,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int SLP_WAKE  = 1,
   parameter int DSLP_WAKE = 4,
   parameter int SD_WAKE   = 16
) (
   input logic                   CLK,
   input logic                   RST,
   sram_pwr_macro_model_if.slave bus
);

   localparam int MAX_WAKE = (SD_WAKE > DSLP_WAKE) ?
                             ((SD_WAKE > SLP_WAKE) ? SD_WAKE : SLP_WAKE) :
                             ((DSLP_WAKE > SLP_WAKE) ? DSLP_WAKE : SLP_WAKE);
   localparam int CNT_W    = $clog2(MAX_WAKE + 1);

   typedef enum logic [2:0] {
      ST_ACTIVE,
      ST_LSLP,
      ST_DSLP,
      ST_SHUT,
      ST_WAKE
   } state_t;

   // Wake counter preload for the sleep state being left (counts down to 0 inclusive).
   function automatic logic [CNT_W-1:0] wake_load(input state_t st);
      case (st)
         ST_LSLP: wake_load = CNT_W'(SLP_WAKE - 1);
         ST_DSLP: wake_load = CNT_W'(DSLP_WAKE - 1);
         default: wake_load = CNT_W'(SD_WAKE - 1);
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pudelay_q, pudelay_d;
   logic               acc_err_q, acc_err_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];

   logic               pin_any;
   state_t             req_st;
   logic               ready;
   logic               in_range;
   logic               rd_en;
   logic               wr_en;
   logic               shut_entry;
   logic [DATA_W-1:0]  rd_data;

   // Addresses can only fall outside the array when DEPTH is not a power of two.
   generate
      if (DEPTH == (1 << ADDR_W)) begin : g_full
         assign in_range = 1'b1;
      end else begin : g_part
         localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
         assign in_range = ({1'b0, bus.A} < DEPTH_LIM);
      end
   endgenerate

   // Power-state next-state logic: SD > DSLP > SLP, any pin overrides, release starts wake-up.
   always_comb begin
      pin_any = bus.SLP | bus.DSLP | bus.SD;
      req_st  = bus.SD ? ST_SHUT : (bus.DSLP ? ST_DSLP : ST_LSLP);
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_ACTIVE: begin
            if (pin_any) state_d = req_st;
         end
         ST_LSLP, ST_DSLP, ST_SHUT: begin
            if (pin_any) begin
               state_d = req_st;
            end else begin
               state_d = ST_WAKE;
               cnt_d   = wake_load(state_q);
            end
         end
         ST_WAKE: begin
            if (pin_any)             state_d = req_st;
            else if (cnt_q == '0)    state_d = ST_ACTIVE;
            else                     cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_ACTIVE;
      endcase
      pudelay_d  = (state_d == ST_WAKE);
      shut_entry = (state_d == ST_SHUT) && (state_q != ST_SHUT);
   end

   // Access qualification: a sleep pin in the same cycle already blocks the access.
   always_comb begin
      ready     = (state_q == ST_ACTIVE) && !pin_any;
      rd_en     = !bus.CEB && ready && bus.WEB;
      wr_en     = !bus.CEB && ready && !bus.WEB && in_range;
      acc_err_d = acc_err_q | (!bus.CEB && !ready);
      rd_data   = in_range ? mem_q[bus.A] : {DATA_W{1'bx}};
   end

   // Power FSM with registered PUDELAY.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_ACTIVE;
         cnt_q     <= '0;
         pudelay_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pudelay_q <= pudelay_d;
      end
   end

   // Sticky access-error flag, cleared only by reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) acc_err_q <= 1'b0;
      else     acc_err_q <= acc_err_d;
   end

   // Array storage: masked writes, contents lost on entry to shutdown, untouched by reset.
   always_ff @(posedge CLK) begin
      if (shut_entry) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= {DATA_W{1'bx}};
      end else if (wr_en) begin
         mem_q[bus.A] <= (mem_q[bus.A] & bus.BWEB) | (bus.D & ~bus.BWEB);
      end
   end

`ifdef SRAM_OUT_REG_EN
   logic [DATA_W-1:0] q1_q, q1_d;
   logic [DATA_W-1:0] q2_q, q2_d;
   logic              rd1_q, rd1_d;

   // Two-stage read pipe; stage 2 only advances behind a stage-1 read capture.
   always_comb begin
      q1_d  = shut_entry ? '0 : (rd_en ? rd_data : q1_q);
      rd1_d = rd_en && !shut_entry;
      q2_d  = shut_entry ? '0 : (rd1_q ? q1_q : q2_q);
   end

   // Output pipeline registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q1_q  <= '0;
         q2_q  <= '0;
         rd1_q <= 1'b0;
      end else begin
         q1_q  <= q1_d;
         q2_q  <= q2_d;
         rd1_q <= rd1_d;
      end
   end

   assign bus.Q = q2_q;
`else
   logic [DATA_W-1:0] q_q, q_d;

   // Single read register holding the last read until the next read or shutdown.
   always_comb begin
      q_d = shut_entry ? '0 : (rd_en ? rd_data : q_q);
   end

   // Output register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) q_q <= '0;
      else     q_q <= q_d;
   end

   assign bus.Q = q_q;
`endif

   assign bus.PUDELAY = pudelay_q;
   assign bus.READY   = ready;
   assign bus.ACC_ERR = acc_err_q;

endmodule
